// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite compositor: direction codes, packed
// colour, transparency/background defaults and the ROM address width helper.
package sprite_pkg;

  typedef enum logic [3:0] {
    DIR_L     = 4'd0,
    DIR_R     = 4'd1,
    DIR_U     = 4'd2,
    DIR_D     = 4'd3,
    DIR_STILL = 4'd4
  } dir_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [23:0] DEF_TRANSP_KEY = 24'hFF00FF;
  localparam logic [23:0] DEF_BG_COLOR   = 24'hFFFFFF;

  function automatic int calc_rom_aw(input int dirs, input int frames, input int words);
    return $clog2(dirs * frames * words);
  endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle between the sprite motion blocks / sprite-sheet ROM and the compositor.
// The master side supplies per-sprite hit/direction/offset and answers ROM reads.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 2,
  parameter int ROM_AW      = 17
);

  logic [NUM_SPRITES-1:0]        is_sprite;
  logic [4*NUM_SPRITES-1:0]      sprite_dir;
  logic [12*NUM_SPRITES-1:0]     sprite_addr;
  logic [ROM_AW*NUM_SPRITES-1:0] rom_addr;
  logic [24*NUM_SPRITES-1:0]     rom_data;

  modport master (
    output is_sprite,
    output sprite_dir,
    output sprite_addr,
    output rom_data,
    input  rom_addr
  );

  modport slave (
    input  is_sprite,
    input  sprite_dir,
    input  sprite_addr,
    input  rom_data,
    output rom_addr
  );

endinterface

// File: rtl/sprite_anim_ctr.sv
// Per-sprite animation frame counter; advances on the shared divider wrap and is
// pinned to frame 0 while the sprite stands still. Changes only on video frame edges.
module sprite_anim_ctr #(
  parameter int FRAMES = 4,
  parameter int FW     = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_rise,
  input  logic          anim_step,
  input  logic          still,
  output logic [FW-1:0] frame
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame <= '0;
    end else if (frame_rise) begin
      if (still) begin
        frame <= '0;
      end else if (anim_step) begin
        frame <= (frame == FW'(FRAMES - 1)) ? '0 : frame + FW'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_compositor.sv
// Three-stage per-pixel compositor: sprite-sheet address generation, ROM access,
// then priority/transparency merge with background and blanking into VGA_R/G/B.
module sprite_compositor
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES  = 2,
  parameter int          NUM_DIRS     = 5,
  parameter int          FRAMES       = 4,
  parameter int          SPRITE_WORDS = 4096,
  parameter int          ANIM_DIV     = 8,
  parameter logic [23:0] TRANSP_KEY   = DEF_TRANSP_KEY,
  parameter logic [23:0] BG_COLOR     = DEF_BG_COLOR
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                frame_clk,
  input  logic                blank_n,
  sprite_compositor_if.slave  bus,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B
);

  localparam int ROM_AW = calc_rom_aw(NUM_DIRS, FRAMES, SPRITE_WORDS);
  localparam int FW     = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  if (SPRITE_WORDS > 4096) begin : g_bad_words
    $fatal(1, "sprite_compositor: SPRITE_WORDS must not exceed 4096");
  end

  logic                          frame_clk_q;
  logic                          frame_rise;
  logic                          anim_step;
  logic [DIV_W-1:0]              anim_div;
  logic [FW-1:0]                 frame_cnt [NUM_SPRITES];
  logic [ROM_AW-1:0]             addr_next [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]        hit_next;
  logic [NUM_SPRITES-1:0]        hit_q;
  logic [NUM_SPRITES-1:0]        hit_d;
  logic                          blank_q;
  logic                          blank_d;
  logic [ROM_AW*NUM_SPRITES-1:0] rom_addr_q;
  rgb_t                          colour;

  assign frame_rise = frame_clk && !frame_clk_q;
  assign anim_step  = frame_rise && (anim_div == DIV_W'(ANIM_DIV - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_clk_q <= 1'b0;
      anim_div    <= '0;
    end else begin
      frame_clk_q <= frame_clk;
      if (frame_rise) begin
        anim_div <= anim_step ? '0 : anim_div + DIV_W'(1);
      end
    end
  end

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_sprite
    logic [3:0]  dir;
    logic [11:0] offset;
    logic        still;
    logic [FW-1:0] frame_eff;

    assign dir       = bus.sprite_dir[4*i +: 4];
    assign offset    = bus.sprite_addr[12*i +: 12];
    assign still     = (dir == DIR_STILL);
    // A sprite that just stopped shows frame 0 at once, before its counter is cleared.
    assign frame_eff = still ? '0 : frame_cnt[i];

    sprite_anim_ctr #(
      .FRAMES (FRAMES),
      .FW     (FW)
    ) u_anim_ctr (
      .clk        (Clk),
      .rst_n      (Reset_n),
      .frame_rise (frame_rise),
      .anim_step  (anim_step),
      .still      (still),
      .frame      (frame_cnt[i])
    );

    assign addr_next[i] = (ROM_AW'(dir) * ROM_AW'(FRAMES) + ROM_AW'(frame_eff))
                          * ROM_AW'(SPRITE_WORDS) + ROM_AW'(offset);
    assign hit_next[i]  = bus.is_sprite[i] && (dir < 4'(NUM_DIRS));
  end

  assign bus.rom_addr = rom_addr_q;

  // Walk from the lowest priority upward so the lowest opaque hit index overwrites the rest.
  always_comb begin
    colour = BG_COLOR;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_d[i] && (bus.rom_data[24*i +: 24] != TRANSP_KEY)) begin
        colour = bus.rom_data[24*i +: 24];
      end
    end
    if (!blank_d) begin
      colour = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      rom_addr_q <= '0;
      hit_q      <= '0;
      hit_d      <= '0;
      blank_q    <= 1'b0;
      blank_d    <= 1'b0;
      VGA_R      <= 8'h00;
      VGA_G      <= 8'h00;
      VGA_B      <= 8'h00;
    end else begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
        rom_addr_q[ROM_AW*i +: ROM_AW] <= addr_next[i];
      end
      hit_q   <= hit_next;
      blank_q <= blank_n;
      hit_d   <= hit_q;
      blank_d <= blank_q;
      VGA_R   <= colour.r;
      VGA_G   <= colour.g;
      VGA_B   <= colour.b;
    end
  end

endmodule
